// File: rtl/iq_pkg.sv
// Shared definitions for the I/Q sample packer: sample-width rules, pair count, FSM states, marker tag.
package iq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [15:0] MARKER_TAG = 16'hDEAD;

    function automatic bit sample_width_legal(input int sw);
        return (sw == 8) || (sw == 16);
    endfunction

    // Number of I/Q pairs packed into one 32-bit FIFO word.
    function automatic int pairs_for(input int sw);
        return 32 / (2 * sw);
    endfunction

endpackage

// File: rtl/sat_counter16.sv
// 16-bit counter with synchronous clear and saturating increment; clear is applied before increment.
module sat_counter16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] cnt
);

    logic [15:0] cnt_r;
    logic [15:0] cnt_nxt_s;

    // Next count: clear-then-increment, holding at all-ones.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (clr) begin
            cnt_nxt_s = inc ? 16'd1 : 16'd0;
        end else if (inc && (cnt_r != 16'hFFFF)) begin
            cnt_nxt_s = cnt_r + 16'd1;
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= 16'd0;
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/iq_fifo_packer.sv
// Packs I/Q pairs into 32-bit words and writes them to the CPU-side FIFO through a one-word holding register.
// Optional IQ_PACKER_MARKER_EN inserts {16'hDEAD, gap} marker words after drops.
module iq_fifo_packer
    import iq_pkg::*;
#(
    parameter int SAMPLE_WIDTH  = 8,
    parameter int FT_DATA_WIDTH = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     enable_i,
    input  logic                     smp_valid_i,
    input  logic [SAMPLE_WIDTH-1:0]  smp_i_i,
    input  logic [SAMPLE_WIDTH-1:0]  smp_q_i,
    output logic [FT_DATA_WIDTH-1:0] fifo_data_o,
    output logic                     fifo_wr_o,
    input  logic                     fifo_full_i,
    input  logic                     ovf_clr_i,
    output logic [15:0]              ovf_cnt_o,
    output logic                     hold_o
);

    localparam int PAIRS = pairs_for(SAMPLE_WIDTH);
    localparam int PW    = 2 * SAMPLE_WIDTH;

    if (!sample_width_legal(SAMPLE_WIDTH)) begin : g_bad_width
        $error("iq_fifo_packer: SAMPLE_WIDTH must be 8 or 16");
    end

    state_t                   state_r;
    state_t                   state_nxt_s;
    logic [1:0]               pidx_r;
    logic [FT_DATA_WIDTH-1:0] acc_r;
    logic [FT_DATA_WIDTH-1:0] hold_data_r;

    logic [PW-1:0]            pair_s;
    logic [FT_DATA_WIDTH-1:0] word_s;
    logic                     hold_valid_s;
    logic                     take_s;
    logic                     last_pair_s;
    logic                     complete_s;
    logic                     wr_s;
    logic                     marker_s;
    logic                     drop_s;
    logic                     load_data_s;

    // Later pairs land in higher bit positions: {Q1,I1,Q0,I0} for 8-bit samples.
    assign pair_s       = {smp_q_i, smp_i_i};
    assign word_s       = acc_r | (FT_DATA_WIDTH'(pair_s) << (PW * pidx_r));
    assign hold_valid_s = (state_r == HOLD);
    assign take_s       = enable_i & smp_valid_i;
    assign last_pair_s  = (pidx_r == 2'(PAIRS - 1));
    assign complete_s   = take_s & last_pair_s;
    assign wr_s         = hold_valid_s & ~fifo_full_i;

`ifdef IQ_PACKER_MARKER_EN
    logic [15:0] gap_s;

    // A pending gap takes the holding register as soon as the current word leaves.
    assign marker_s = wr_s & (gap_s != 16'd0);

    sat_counter16 u_gap (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .clr   (marker_s),
        .inc   (drop_s),
        .cnt   (gap_s)
    );
`else
    assign marker_s = 1'b0;
`endif

    assign drop_s      = complete_s & ((hold_valid_s & fifo_full_i) | marker_s);
    assign load_data_s = complete_s & ~drop_s;

    // Next-state logic for the packer FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (enable_i) begin
                    state_nxt_s = load_data_s ? HOLD : FILL;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FILL: begin
                if (!enable_i) begin
                    state_nxt_s = IDLE;
                end else if (load_data_s) begin
                    state_nxt_s = HOLD;
                end else begin
                    state_nxt_s = FILL;
                end
            end
            HOLD: begin
                if (marker_s || load_data_s) begin
                    state_nxt_s = HOLD;
                end else if (wr_s) begin
                    state_nxt_s = enable_i ? FILL : IDLE;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Pair index and partial-word accumulator; disabling throws the partial word away.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            pidx_r <= 2'd0;
            acc_r  <= '0;
        end else if (!enable_i) begin
            pidx_r <= 2'd0;
            acc_r  <= '0;
        end else if (take_s) begin
            if (last_pair_s) begin
                pidx_r <= 2'd0;
                acc_r  <= '0;
            end else begin
                pidx_r <= 2'(pidx_r + 2'd1);
                acc_r  <= word_s;
            end
        end else begin
            pidx_r <= pidx_r;
            acc_r  <= acc_r;
        end
    end

    // Holding register: marker wins over a completing data word, which is then dropped.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            hold_data_r <= '0;
        end else if (marker_s) begin
`ifdef IQ_PACKER_MARKER_EN
            hold_data_r <= FT_DATA_WIDTH'({MARKER_TAG, gap_s});
`else
            hold_data_r <= hold_data_r;
`endif
        end else if (load_data_s) begin
            hold_data_r <= word_s;
        end else begin
            hold_data_r <= hold_data_r;
        end
    end

    sat_counter16 u_ovf (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .clr   (ovf_clr_i),
        .inc   (drop_s),
        .cnt   (ovf_cnt_o)
    );

    assign fifo_wr_o   = wr_s;
    assign fifo_data_o = hold_data_r;
    assign hold_o      = hold_valid_s;

endmodule
